// File: rtl/pc_seq_pkg.sv
// Shared types and parameter defaults for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEFAULT     = 10;
  localparam int unsigned OFF_W_DEFAULT    = 9;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  // Instruction sequencing states
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } seq_state_e;

endpackage

// File: rtl/pc_increment.sv
// Program counter +1 path; wraps modulo 2^WIDTH.
module pc_increment #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] incremented
);

  // Plain increment, carry out discarded so the PC wraps
  always_comb begin
    incremented = value + WIDTH'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/execute sequencer for the 9-bit CPU.
// Optional retire counter output enabled by defining PC_SEQ_RETIRE_COUNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEFAULT,
  parameter int unsigned     OFF_W    = OFF_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  output logic             ir_valid,
  input  logic             stall,
  input  logic             halt_i,
  input  logic             br_en,
  input  logic             br_abs,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc,
`ifdef PC_SEQ_RETIRE_COUNT_EN
  output logic [15:0]      retire_cnt,
`endif
  output logic             halted
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] pc_rel;

  pc_increment #(
    .WIDTH(PC_W)
  ) u_pc_increment (
    .value       (pc_q),
    .incremented (pc_inc)
  );

  // Sign-extend the branch offset so the add wraps in both directions
  always_comb begin
    off_ext = PC_W'($signed(br_off));
    pc_rel  = pc_q + off_ext;
  end

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next PC; in EXEC halt beats stall, stall beats branch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) state_d = StExec;
      end
      StExec: begin
        if (halt_i) begin
          state_d = StHalt;
        end else if (!stall) begin
          state_d = StFetch;
          if (br_en && br_abs) begin
            pc_d = br_target;
          end else if (br_en) begin
            pc_d = pc_rel;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    imem_req  = (state_q == StFetch);
    ir_valid  = (state_q == StExec);
    halted    = (state_q == StHalt);
    imem_addr = pc_q;
    pc        = pc_q;
  end

`ifdef PC_SEQ_RETIRE_COUNT_EN
  logic [15:0] retire_q;

  // Count instructions that leave EXEC for the next fetch; cleared on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (state_q == StHalt && start) begin
      retire_q <= '0;
    end else if (state_q == StExec && !halt_i && !stall) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int OFF_W = 9;
  localparam int PC_MOD = 1 << PC_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic             ir_valid;
  logic             stall;
  logic             halt_i;
  logic             br_en;
  logic             br_abs;
  logic [OFF_W-1:0] br_off;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  pc;
  logic             halted;
`ifdef PC_SEQ_RETIRE_COUNT_EN
  logic [15:0]      retire_cnt;
`endif

  int checks = 0;
  int passes = 0;
  int m_pc = 0;
  int m_retire = 0;

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .ir_valid  (ir_valid),
    .stall     (stall),
    .halt_i    (halt_i),
    .br_en     (br_en),
    .br_abs    (br_abs),
    .br_off    (br_off),
    .br_target (br_target),
    .pc        (pc),
`ifdef PC_SEQ_RETIRE_COUNT_EN
    .retire_cnt(retire_cnt),
`endif
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Reference rule for the PC chosen when an instruction leaves EXEC
  function automatic int model_next(int cur, bit en, bit abs_j, int off, int tgt);
    if (!en) return (cur + 1) % PC_MOD;
    if (abs_j) return tgt % PC_MOD;
    return (((cur + off) % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    start     = 1'b0;
    imem_ack  = 1'b0;
    stall     = 1'b0;
    halt_i    = 1'b0;
    br_en     = 1'b0;
    br_abs    = 1'b0;
    br_off    = '0;
    br_target = '0;
  endtask

  // From FETCH: execute one absolute jump, then fetch so the DUT sits in EXEC at target
  task automatic enter_exec_at(input int target);
    quiet_inputs();
    imem_ack = 1'b1;
    tick();
    imem_ack  = 1'b0;
    br_en     = 1'b1;
    br_abs    = 1'b1;
    br_target = target[PC_W-1:0];
    tick();
    m_pc = target;
    m_retire++;
    quiet_inputs();
    imem_ack = 1'b1;
    tick();
    quiet_inputs();
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || halted !== 1'b0 || pc !== 10'h000)
      $display("FAIL reset_state: req=%b irv=%b halted=%b pc=%h, want 0 0 0 000",
               imem_req, ir_valid, halted, pc);
    else passes++;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    checks++;
    if (retire_cnt !== 16'd0) $display("FAIL reset_retire: got %0d want 0", retire_cnt);
    else passes++;
`endif
    rst_n = 1'b1;
    imem_ack = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL idle_no_start: req=%b irv=%b want 0 0", imem_req, ir_valid);
    else passes++;
    m_pc = 0;
    m_retire = 0;
  endtask

  // Ack tied high: addresses 0,1,2,3 every second cycle, ir_valid alternating
  task automatic test_sequential();
    start = 1'b1;
    tick();
    start    = 1'b0;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== m_pc[PC_W-1:0])
        $display("FAIL seq_fetch[%0d]: req=%b irv=%b addr=%h, want 1 0 %h",
                 i, imem_req, ir_valid, imem_addr, m_pc[PC_W-1:0]);
      else passes++;
      tick();
      checks++;
      if (imem_req !== 1'b0 || ir_valid !== 1'b1 || pc !== m_pc[PC_W-1:0])
        $display("FAIL seq_exec[%0d]: req=%b irv=%b pc=%h, want 0 1 %h",
                 i, imem_req, ir_valid, pc, m_pc[PC_W-1:0]);
      else passes++;
      tick();
      m_pc = model_next(m_pc, 1'b0, 1'b0, 0, 0);
      m_retire++;
    end
    quiet_inputs();
  endtask

  task automatic test_branch();
    enter_exec_at(12'h010);
    br_en  = 1'b1;
    br_off = 9'h1FC;
    tick();
    m_pc = model_next(m_pc, 1'b1, 1'b0, -4, 0);
    m_retire++;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h00C)
      $display("FAIL branch_rel_neg: req=%b addr=%h, want 1 00c", imem_req, imem_addr);
    else passes++;
    quiet_inputs();
    imem_ack = 1'b1;
    tick();
    br_en     = 1'b1;
    br_abs    = 1'b1;
    br_target = 10'h3F0;
    tick();
    m_pc = 12'h3F0;
    m_retire++;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h3F0)
      $display("FAIL branch_abs: req=%b addr=%h, want 1 3f0", imem_req, imem_addr);
    else passes++;
    quiet_inputs();
  endtask

  task automatic test_wrap();
    enter_exec_at(12'h3FF);
    tick();
    m_pc = model_next(m_pc, 1'b0, 1'b0, 0, 0);
    m_retire++;
    checks++;
    if (imem_addr !== 10'h000) $display("FAIL wrap_inc: addr=%h want 000", imem_addr);
    else passes++;
    enter_exec_at(1);
    br_en  = 1'b1;
    br_off = 9'h1FE;
    tick();
    m_pc = model_next(m_pc, 1'b1, 1'b0, -2, 0);
    m_retire++;
    checks++;
    if (imem_addr !== 10'h3FF) $display("FAIL wrap_rel_m2: addr=%h want 3ff", imem_addr);
    else passes++;
    enter_exec_at(2);
    br_en  = 1'b1;
    br_off = 9'h1FD;
    tick();
    m_pc = model_next(m_pc, 1'b1, 1'b0, -3, 0);
    m_retire++;
    checks++;
    if (imem_addr !== 10'h3FF) $display("FAIL wrap_rel_m3: addr=%h want 3ff", imem_addr);
    else passes++;
    quiet_inputs();
  endtask

  task automatic test_stall_branch();
    enter_exec_at(12'h100);
    stall  = 1'b1;
    br_en  = 1'b1;
    br_off = 9'h005;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 10'h100)
        $display("FAIL stall_hold[%0d]: irv=%b req=%b pc=%h, want 1 0 100",
                 i, ir_valid, imem_req, pc);
      else passes++;
    end
    stall = 1'b0;
    tick();
    m_pc = model_next(m_pc, 1'b1, 1'b0, 5, 0);
    m_retire++;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h105)
      $display("FAIL stall_release_branch: req=%b addr=%h, want 1 105", imem_req, imem_addr);
    else passes++;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    checks++;
    if (retire_cnt !== 16'(m_retire))
      $display("FAIL stall_retire: got %0d want %0d", retire_cnt, m_retire);
    else passes++;
`endif
    quiet_inputs();
  endtask

  task automatic test_halt();
    enter_exec_at(12'h020);
    halt_i = 1'b1;
    br_en  = 1'b1;
    stall  = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0 || pc !== 10'h020)
      $display("FAIL halt_enter: halted=%b req=%b irv=%b pc=%h, want 1 0 0 020",
               halted, imem_req, ir_valid, pc);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      imem_ack  = 1'($urandom);
      br_en     = 1'($urandom);
      br_abs    = 1'($urandom);
      br_target = 10'($urandom);
      tick();
    end
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 10'h020)
      $display("FAIL halt_hold: halted=%b req=%b pc=%h, want 1 0 020", halted, imem_req, pc);
    else passes++;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    checks++;
    if (retire_cnt !== 16'(m_retire))
      $display("FAIL halt_retire_hold: got %0d want %0d", retire_cnt, m_retire);
    else passes++;
`endif
    quiet_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = 0;
    m_retire = 0;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h000)
      $display("FAIL halt_restart: halted=%b req=%b addr=%h, want 0 1 000",
               halted, imem_req, imem_addr);
    else passes++;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    checks++;
    if (retire_cnt !== 16'd0) $display("FAIL restart_retire: got %0d want 0", retire_cnt);
    else passes++;
`endif
  endtask

  // Random stream: ack latency, stalls, branches, occasional halt and noise on ignored inputs
  task automatic test_random();
    int wait_n;
    int stall_n;
    int off;
    int tgt;
    bit en;
    bit abs_j;
    for (int n = 0; n < 150; n++) begin
      wait_n = $urandom_range(0, 3);
      for (int w = 0; w < wait_n; w++) begin
        imem_ack = 1'b0;
        start    = 1'($urandom);
        halt_i   = 1'($urandom);
        stall    = 1'($urandom);
        br_en    = 1'($urandom);
        tick();
        checks++;
        if (imem_req !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== m_pc[PC_W-1:0])
          $display("FAIL rnd_fetch_wait[%0d]: req=%b irv=%b addr=%h, want 1 0 %h",
                   n, imem_req, ir_valid, imem_addr, m_pc[PC_W-1:0]);
        else passes++;
      end
      quiet_inputs();
      imem_ack = 1'b1;
      tick();
      checks++;
      if (ir_valid !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc[PC_W-1:0])
        $display("FAIL rnd_exec[%0d]: irv=%b req=%b pc=%h, want 1 0 %h",
                 n, ir_valid, imem_req, pc, m_pc[PC_W-1:0]);
      else passes++;
      stall_n = $urandom_range(0, 2);
      for (int s = 0; s < stall_n; s++) begin
        stall     = 1'b1;
        imem_ack  = 1'($urandom);
        br_en     = 1'($urandom);
        br_abs    = 1'($urandom);
        br_target = 10'($urandom);
        tick();
      end
      if (stall_n > 0) begin
        checks++;
        if (ir_valid !== 1'b1 || pc !== m_pc[PC_W-1:0])
          $display("FAIL rnd_stall[%0d]: irv=%b pc=%h, want 1 %h",
                   n, ir_valid, pc, m_pc[PC_W-1:0]);
        else passes++;
      end
      quiet_inputs();
      imem_ack = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        halt_i = 1'b1;
        br_en  = 1'($urandom);
        tick();
        checks++;
        if (halted !== 1'b1 || pc !== m_pc[PC_W-1:0])
          $display("FAIL rnd_halt[%0d]: halted=%b pc=%h, want 1 %h",
                   n, halted, pc, m_pc[PC_W-1:0]);
        else passes++;
        quiet_inputs();
        start = 1'b1;
        tick();
        m_pc = 0;
        m_retire = 0;
      end else begin
        en    = 1'($urandom);
        abs_j = 1'($urandom);
        off   = int'($urandom_range(0, 511)) - 256;
        tgt   = int'($urandom_range(0, PC_MOD - 1));
        br_en     = en;
        br_abs    = abs_j;
        br_off    = off[OFF_W-1:0];
        br_target = tgt[PC_W-1:0];
        tick();
        m_pc = model_next(m_pc, en, abs_j, off, tgt);
        m_retire++;
      end
      quiet_inputs();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc[PC_W-1:0])
        $display("FAIL rnd_next_pc[%0d]: req=%b addr=%h, want 1 %h",
                 n, imem_req, imem_addr, m_pc[PC_W-1:0]);
      else passes++;
`ifdef PC_SEQ_RETIRE_COUNT_EN
      checks++;
      if (retire_cnt !== 16'(m_retire))
        $display("FAIL rnd_retire[%0d]: got %0d want %0d", n, retire_cnt, m_retire);
      else passes++;
`endif
    end
  endtask

  // Ack withheld, then asynchronous reset between clock edges
  task automatic test_reset_mid_fetch();
    quiet_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc[PC_W-1:0])
        $display("FAIL ack_withheld[%0d]: req=%b addr=%h, want 1 %h",
                 i, imem_req, imem_addr, m_pc[PC_W-1:0]);
      else passes++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || halted !== 1'b0 || pc !== 10'h000)
      $display("FAIL async_reset: req=%b irv=%b halted=%b pc=%h, want 0 0 0 000",
               imem_req, ir_valid, halted, pc);
    else passes++;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    checks++;
    if (retire_cnt !== 16'd0) $display("FAIL async_reset_retire: got %0d want 0", retire_cnt);
    else passes++;
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_stall_branch();
    test_halt();
    test_random();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
